draw_car: RTL and testbench

//  VGA pipeline stage that overlays the 64x64 player-car sprite on the video stream.

---
 rtl/draw_car_pkg.sv | 26 ++
 rtl/car_pos_buf.sv | 46 ++++
 rtl/draw_car.sv | 105 ++++++++++
 tb/tb_draw_car.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/draw_car_pkg.sv
// Shared VGA bus layout and player-car sprite constants for the draw_car pipeline stage.
package draw_car_pkg;

    typedef struct packed {
        logic [10:0] vcount;
        logic        vsync;
        logic        vblnk;
        logic [10:0] hcount;
        logic        hsync;
        logic        hblnk;
        logic [11:0] rgb;
    } vga_bus_t;

    localparam int unsigned VGA_BUS_SIZE = $bits(vga_bus_t);

    localparam int unsigned CAR_W        = 64;
    localparam int unsigned CAR_H        = 64;
    localparam logic [11:0] CAR_KEY_RGB  = 12'hF0F;
    localparam logic [11:0] CAR_ROAD_RGB = 12'h444;

    function automatic logic sprite_opaque(input logic in_box, input logic [11:0] spr,
                                           input logic [11:0] key);
        return in_box && (spr != key);
    endfunction

endpackage

// File: rtl/car_pos_buf.sv
// Double-buffered sprite position: pending loads on a strobe, active follows at each vsync rise.
module car_pos_buf (
    input  logic        i_pclk,
    input  logic        i_rst,
    input  logic        i_vsync,
    input  logic        i_pos_valid,
    input  logic [11:0] i_xpos,
    input  logic [11:0] i_ypos,
    output logic [11:0] o_xact,
    output logic [11:0] o_yact,
    output logic        o_vsync_rise
);

    logic        r_vsync_prev;
    logic [11:0] r_xpend, r_ypend;
    logic [11:0] r_xact, r_yact;
    logic        w_vsync_rise;

    assign w_vsync_rise = i_vsync && !r_vsync_prev;

    // A strobe coinciding with the vsync rise lands in pending only; active takes the old pending.
    always_ff @(posedge i_pclk) begin
        if (i_rst) begin
            r_vsync_prev <= 1'b0;
            r_xpend      <= '0;
            r_ypend      <= '0;
            r_xact       <= '0;
            r_yact       <= '0;
        end else begin
            r_vsync_prev <= i_vsync;
            if (i_pos_valid) begin
                r_xpend <= i_xpos;
                r_ypend <= i_ypos;
            end
            if (w_vsync_rise) begin
                r_xact <= r_xpend;
                r_yact <= r_ypend;
            end
        end
    end

    assign o_xact       = r_xact;
    assign o_yact       = r_yact;
    assign o_vsync_rise = w_vsync_rise;

endmodule

// File: rtl/draw_car.sv
// Overlays the player-car sprite on the VGA stream through a fixed 2-cycle pipeline.
// Build option DRAW_CAR_COLLISION_EN adds the per-frame collision pulse.
module draw_car
    import draw_car_pkg::*;
#(
    parameter int unsigned SPR_W    = CAR_W,
    parameter int unsigned SPR_H    = CAR_H,
    parameter logic [11:0] KEY_RGB  = CAR_KEY_RGB,
    parameter logic [11:0] ROAD_RGB = CAR_ROAD_RGB
) (
    input  logic        pclk,
    input  logic        rst,
    input  vga_bus_t    vga_in,
    output vga_bus_t    vga_out,
    input  logic [11:0] xpos_in,
    input  logic [11:0] ypos_in,
    input  logic        pos_valid,
    output logic [11:0] rom_addr,
    input  logic [11:0] rom_rgb,
    output logic        collision
);

    localparam int unsigned AW = $clog2(SPR_W);
    localparam int unsigned AH = $clog2(SPR_H);

    logic [11:0] w_xact, w_yact;
    logic        w_vsync_rise;
    logic [12:0] w_h, w_v, w_x, w_y, w_dx, w_dy;
    logic        w_in_box, w_draw;
    logic        w_unused;
    vga_bus_t    r_d1, r_out;
    logic        r_box1;

    car_pos_buf u_pos_buf (
        .i_pclk      (pclk),
        .i_rst       (rst),
        .i_vsync     (vga_in.vsync),
        .i_pos_valid (pos_valid),
        .i_xpos      (xpos_in),
        .i_ypos      (ypos_in),
        .o_xact      (w_xact),
        .o_yact      (w_yact),
        .o_vsync_rise(w_vsync_rise)
    );

    assign w_h  = {2'b00, vga_in.hcount};
    assign w_v  = {2'b00, vga_in.vcount};
    assign w_x  = {1'b0, w_xact};
    assign w_y  = {1'b0, w_yact};
    assign w_dx = w_h - w_x;
    assign w_dy = w_v - w_y;

    // 13-bit compares keep a sprite placed near 4095 from wrapping back onto the screen.
    assign w_in_box = !vga_in.hblnk && !vga_in.vblnk
                   && (w_h >= w_x) && (w_h < w_x + 13'(SPR_W))
                   && (w_v >= w_y) && (w_v < w_y + 13'(SPR_H));

    assign rom_addr = 12'({w_dy[AH-1:0], w_dx[AW-1:0]});

    // rom_rgb arrives one cycle after rom_addr, aligned with box1/d1.
    assign w_draw = sprite_opaque(r_box1, rom_rgb, KEY_RGB);

    always_ff @(posedge pclk) begin
        if (rst) begin
            r_d1   <= '0;
            r_box1 <= 1'b0;
            r_out  <= '0;
        end else begin
            r_d1      <= vga_in;
            r_box1    <= w_in_box;
            r_out     <= r_d1;
            r_out.rgb <= w_draw ? rom_rgb : r_d1.rgb;
        end
    end

    assign vga_out = r_out;

`ifdef DRAW_CAR_COLLISION_EN
    logic r_flag, r_collision;
    logic w_hit;

    assign w_hit = w_draw && (r_d1.rgb != ROAD_RGB);

    // A hit on the vsync-rise edge seeds the next frame's flag instead of being lost.
    always_ff @(posedge pclk) begin
        if (rst) begin
            r_flag      <= 1'b0;
            r_collision <= 1'b0;
        end else if (w_vsync_rise) begin
            r_collision <= r_flag;
            r_flag      <= w_hit;
        end else begin
            r_collision <= 1'b0;
            r_flag      <= r_flag | w_hit;
        end
    end

    assign collision = r_collision;
    assign w_unused  = ^{w_dx[12:AW], w_dy[12:AH]};
`else
    assign collision = 1'b0;
    assign w_unused  = ^{w_dx[12:AW], w_dy[12:AH], ROAD_RGB, w_vsync_rise};
`endif

endmodule

// File: tb/tb_draw_car.sv
// Randomized bench for draw_car: a pixel-level reference model predicts vga_out and collision.
module tb_draw_car;
    import draw_car_pkg::*;

    logic        pclk = 1'b0;
    logic        rst;
    vga_bus_t    vga_in, vga_out;
    logic [11:0] xpos_in, ypos_in, rom_addr, rom_rgb;
    logic        pos_valid, collision;

    int checks = 0;
    int errors = 0;
    string phase = "init";

    // model state
    int       m_px, m_py, m_ax, m_ay;
    bit       m_prev_vs, m_flag, m_hit_prev;
    int       bg_mode = 0;
    vga_bus_t exp_q[$];

    always #5 pclk = ~pclk;

    draw_car dut (
        .pclk     (pclk),
        .rst      (rst),
        .vga_in   (vga_in),
        .vga_out  (vga_out),
        .xpos_in  (xpos_in),
        .ypos_in  (ypos_in),
        .pos_valid(pos_valid),
        .rom_addr (rom_addr),
        .rom_rgb  (rom_rgb),
        .collision(collision)
    );

    // ROM model: echoes its address, address 0 holds the key colour.
    function automatic logic [11:0] rom_f(input logic [11:0] a);
        return (a == 12'h000) ? 12'hF0F : a;
    endfunction

    always @(posedge pclk) rom_rgb <= rom_f(rom_addr);

    function automatic vga_bus_t pix(input int h, input int v, input logic [11:0] rgb,
                                     input logic vs);
        vga_bus_t p;
        p.hcount = 11'(h);
        p.vcount = 11'(v);
        p.hblnk  = (h >= 800);
        p.vblnk  = (v >= 600);
        p.hsync  = (h >= 840) && (h < 968);
        p.vsync  = vs;
        p.rgb    = rgb;
        return p;
    endfunction

    function automatic logic [11:0] bgc();
        case (bg_mode)
            1:       return 12'h0F0;
            2:       return 12'h444;
            default: return ($urandom_range(0, 2) == 0) ? 12'h444 : 12'($urandom);
        endcase
    endfunction

    function automatic int urange(input int lo, input int hi);
        return lo + int'($urandom_range(0, hi - lo));
    endfunction

    task automatic check_out(input vga_bus_t e, input logic ec);
        checks++;
        assert (vga_out === e) else begin
            errors++;
            $error("FAIL %s vga_out: got %h expected %h", phase, vga_out, e);
        end
        checks++;
        assert (collision === ec) else begin
            errors++;
            $error("FAIL %s collision: got %b expected %b", phase, collision, ec);
        end
    endtask

    task automatic cycle(input logic r, input vga_bus_t vin, input logic pv, input int x,
                         input int y);
        vga_bus_t e;
        logic     inbox, hit, rise, ec;
        int       dx, dy;
        logic [11:0] spr;
        rst = r; vga_in = vin; pos_valid = pv; xpos_in = 12'(x); ypos_in = 12'(y);
        if (r) begin
            m_px = 0; m_py = 0; m_ax = 0; m_ay = 0;
            m_prev_vs = 0; m_flag = 0; m_hit_prev = 0;
            exp_q.delete();
            exp_q.push_back('0);
            @(posedge pclk); #1;
            check_out('0, 1'b0);
            return;
        end
        dx = int'(vin.hcount) - m_ax;
        dy = int'(vin.vcount) - m_ay;
        inbox = !vin.hblnk && !vin.vblnk && dx >= 0 && dx < 64 && dy >= 0 && dy < 64;
        spr = inbox ? rom_f(12'(dy * 64 + dx)) : 12'h000;
        e = vin;
        hit = 1'b0;
        if (inbox && spr != 12'hF0F) begin
            e.rgb = spr;
            hit = (vin.rgb != 12'h444);
        end
        exp_q.push_back(e);
        rise = vin.vsync && !m_prev_vs;
        if (rise) begin
            ec = m_flag; m_flag = m_hit_prev;
            m_ax = m_px; m_ay = m_py;
        end else begin
            ec = 1'b0; m_flag = m_flag | m_hit_prev;
        end
        m_hit_prev = hit;
        if (pv) begin m_px = x; m_py = y; end
        m_prev_vs = vin.vsync;
`ifndef DRAW_CAR_COLLISION_EN
        ec = 1'b0;
`endif
        @(posedge pclk); #1;
        if (exp_q.size() >= 2) check_out(exp_q.pop_front(), ec);
    endtask

    task automatic set_pos(input int x, input int y);
        cycle(0, pix(900, 610, bgc(), 0), 1, x, y);
    endtask

    task automatic frame_start(input logic pv, input int x, input int y);
        cycle(0, pix(0, 601, bgc(), 0), 0, 0, 0);
        cycle(0, pix(0, 601, bgc(), 1), pv, x, y);
        cycle(0, pix(0, 602, bgc(), 1), 0, 0, 0);
    endtask

    task automatic run_rand(input int n, input int hlo, input int hhi, input int vlo,
                            input int vhi);
        for (int i = 0; i < n; i++)
            cycle(0, pix(urange(hlo, hhi), urange(vlo, vhi), bgc(), 0), 0, 0, 0);
    endtask

    initial begin
        vga_in = '0; pos_valid = 0; xpos_in = 0; ypos_in = 0; rst = 1;

        phase = "reset";
        for (int i = 0; i < 5; i++) cycle(1, pix(urange(0, 1055), urange(0, 627), bgc(), 0), 0, 0, 0);
        phase = "passthru";
        run_rand(40, 0, 1055, 0, 627);
        run_rand(30, 0, 70, 0, 70);

        phase = "pos100_200";
        set_pos(100, 200);
        frame_start(0, 0, 0);
        cycle(0, pix(100, 200, 12'h123, 0), 0, 0, 0);
        cycle(0, pix(101, 200, 12'h123, 0), 0, 0, 0);
        cycle(0, pix(163, 263, 12'h123, 0), 0, 0, 0);
        cycle(0, pix(164, 200, 12'h123, 0), 0, 0, 0);
        cycle(0, pix(99, 200, 12'h123, 0), 0, 0, 0);
        cycle(0, pix(100, 264, 12'h123, 0), 0, 0, 0);
        run_rand(150, 90, 175, 190, 275);

        phase = "pv_at_vsync";
        frame_start(1, 300, 100);
        run_rand(80, 90, 175, 190, 275);
        run_rand(60, 290, 375, 90, 175);
        frame_start(0, 0, 0);
        run_rand(60, 90, 175, 190, 275);
        run_rand(80, 290, 375, 90, 175);

        phase = "edge780_580";
        set_pos(780, 580);
        frame_start(0, 0, 0);
        run_rand(200, 760, 1055, 560, 627);
        run_rand(60, 0, 70, 0, 70);

        phase = "wrap4090";
        set_pos(4090, 0);
        frame_start(0, 0, 0);
        run_rand(100, 0, 2047, 0, 100);
        run_rand(60, 0, 70, 0, 70);

        phase = "collision";
        bg_mode = 1;
        set_pos(100, 200);
        frame_start(0, 0, 0);
        run_rand(100, 90, 175, 190, 275);
        frame_start(0, 0, 0);
        bg_mode = 2;
        run_rand(100, 90, 175, 190, 275);
        frame_start(0, 0, 0);
        frame_start(0, 0, 0);

        phase = "mid_reset";
        bg_mode = 0;
        run_rand(10, 0, 120, 0, 120);
        cycle(1, pix(10, 10, 12'hABC, 0), 0, 0, 0);
        cycle(1, pix(11, 10, 12'hABC, 0), 0, 0, 0);
        run_rand(20, 0, 120, 0, 120);

        phase = "random";
        for (int i = 0; i < 400; i++) begin
            cycle(0, pix(urange(0, 300), urange(0, 300), bgc(), ($urandom_range(0, 7) == 0)),
                  ($urandom_range(0, 15) == 0), urange(0, 200), urange(0, 200));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
